dte_diag_seq: RTL and testbench
===============================

DTE_DIAG_SEQ -- requirements
Module: dte_diag_seq

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1: cycles ds/data are driven before the diagnostic strobe.
REQ-002 SHALL have parameter STROBE_CYC, default 2: cycles diagStrobe is held high.
REQ-003 SHALL have parameter HOLD_CYC, default 1: cycles ds/data are held after the strobe drops.
REQ-004 SHALL have ports, each written as name, direction, width, meaning:
- clk  in  1  EBUS clock (CLK.EBUS_CLK); all logic on posedge.
- CROBAR  in  1  reset; synchronous, active-high.
- reqValid  in  2  per-requester request; [0]=front-end, [1]=maintenance.
- reqType0, reqType1  in  2 each  tFEReqType: DiagFunc, DiagRead, DiagWrite, Misc.
- reqDs0, reqDs1  in  7 each  diagnostic function code.
- reqData0, reqData1  in  36 each  write data.
- reqAck  out  2  one-cycle completion pulse per requester.
- replyData  out  36  sampled EBUS data, valid with reqAck.
- ebusDataIn  in  36  EBUS.data.
- ds  out  7  EBUS.ds.
- diagStrobe  out  1  EBUS.diagStrobe.
- driving  out  1  EBUSdriver.driving.
- drvData  out  36  EBUSdriver.data.
- miscStrobe  out  1  one-cycle pulse for Misc requests.
- miscCode  out  7  Misc code, valid with miscStrobe.
- busy  out  1  high in every state except IDLE.

Function
REQ-005 SHALL use the states IDLE, SETUP, STROBE, HOLD and DONE.
REQ-006 IDLE: if any reqValid bit is set, SHALL grant round-robin; ties go to the requester not granted last; after reset, requester 0 wins a tie.
REQ-007 SHALL latch type, ds and data of the granted request at the grant; later changes to that requester's inputs SHALL be ignored until its ack.
REQ-008 Granted Misc request: IDLE->DONE; miscStrobe=1 and miscCode=ds in the DONE cycle; no EBUS activity.
REQ-009 Granted non-Misc request: IDLE->SETUP; ds is driven; for DiagWrite, driving=1 and drvData=data; otherwise driving=0 and drvData=0.
REQ-010 SETUP SHALL last SETUP_CYC cycles, then go to STROBE.
REQ-011 STROBE SHALL last STROBE_CYC cycles with diagStrobe=1, then go to HOLD.
REQ-012 On the last STROBE cycle, SHALL capture ebusDataIn into replyData for DiagRead and DiagFunc; for DiagWrite, replyData=drvData.
REQ-013 HOLD SHALL last HOLD_CYC cycles with diagStrobe=0 and ds/driving unchanged, then go to DONE.
REQ-014 DONE SHALL last one cycle: reqAck[granted]=1, driving=0, drvData=0, ds=0, then return to IDLE.
REQ-015 Next grant is at the earliest in the cycle after DONE, so reqAck is never back-to-back.
REQ-016 Non-Misc latency, grant cycle to ack cycle: 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles; with defaults, 5.
REQ-017 Requester handshake: hold reqValid until its reqAck; deassertion before ack SHALL NOT abort the cycle in progress.
REQ-018 A parameter of 0 SHALL skip that phase, except STROBE_CYC, which SHALL be clamped to at least 1.
REQ-019 Cycle counter SHALL be 8 bits; parameters above 255 are illegal (elaboration assertion).

Reset
REQ-020 CROBAR=1 SHALL force IDLE, last-grant=1, and all outputs to 0 (including replyData), on the next clk edge.
REQ-021 CROBAR asserted mid-cycle SHALL abort without ack; diagStrobe and driving SHALL fall in the reset cycle.

Structure
REQ-022 tFEReqType, tMiscFuncType and the default timing constants SHALL reside in shared package dte_pkg, also imported by dte.
REQ-023 The round-robin grant SHALL be a sub-module dte_rr_arb2 (inputs: 2 requests, enable, lastGrant; output: one-hot grant).

Verification
REQ-024 Front-end DiagRead ds=7'o014, ebusDataIn=36'o123456701234 -> diagStrobe high on cycles 2-3 after grant; reqAck[0] at cycle 5 with replyData=36'o123456701234.
REQ-025 Maintenance DiagWrite ds=7'o071, data=36'o777000777000 -> driving=1 and drvData stable from SETUP through HOLD; driving=0 on the ack cycle.
REQ-026 Both requesters continuously valid -> grants alternate 0,1,0,1; acks six cycles apart; no back-to-back acks.
REQ-027 Misc clrCROBAR from front-end -> miscStrobe pulse with miscCode=0 one cycle after grant; diagStrobe never asserted.
REQ-028 CROBAR pulsed during STROBE -> next cycle diagStrobe=0, driving=0, no reqAck; a pending request is regranted with requester 0 priority.
REQ-029 SETUP_CYC=0, HOLD_CYC=0, STROBE_CYC=0 -> a DiagRead acks 2 cycles after grant with a single strobe cycle.

Source files
------------

// File: rtl/dte_pkg.sv
// rtl/dte_pkg.sv - shared types and timing defaults for the DTE diagnostic path
// Contents: front-end request types, misc function codes, sequencer states,
// default SETUP/STROBE/HOLD cycle counts and the counter range limit.
package dte_pkg;

  typedef enum logic [1:0] {
    DiagFunc  = 2'd0,
    DiagRead  = 2'd1,
    DiagWrite = 2'd2,
    Misc      = 2'd3
  } tFEReqType;

  typedef enum logic [6:0] {
    clrCROBAR = 7'o00,
    setCROBAR = 7'o01,
    clrRUN    = 7'o02,
    setRUN    = 7'o03,
    conBUT    = 7'o04,
    stopCLK   = 7'o05,
    startCLK  = 7'o06
  } tMiscFuncType;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } tDiagState;

  localparam int unsigned DTE_SETUP_CYC  = 1;
  localparam int unsigned DTE_STROBE_CYC = 2;
  localparam int unsigned DTE_HOLD_CYC   = 1;
  localparam int unsigned DTE_CNT_MAX    = 255;

  // A zero-length strobe would never sample the bus, so it is stretched to one cycle.
  function automatic int unsigned dte_clamp1(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/dte_rr_arb2.sv
// rtl/dte_rr_arb2.sv - two-way round-robin grant for the diagnostic sequencer
// Ports: req_i[1:0] requests (bit 0 front-end, bit 1 maintenance); en_i allows a
// grant this cycle; last_grant_i index of the previous winner; grant_o one-hot
// grant, all zero when disabled or nothing is requested.
module dte_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      // On a tie the requester that did not win last time goes first.
      if (req_i == 2'b11) begin
        grant_o = last_grant_i ? 2'b01 : 2'b10;
      end else begin
        grant_o = req_i;
      end
    end
  end

endmodule

// File: rtl/dte_diag_seq.sv
// rtl/dte_diag_seq.sv - EBUS diagnostic cycle sequencer for two requesters
// Ports: clk, CROBAR (sync active-high reset); reqValid/reqType*/reqDs*/reqData*
// request inputs; reqAck/replyData completion; ebusDataIn bus sample input;
// ds/diagStrobe/driving/drvData EBUS drive; miscStrobe/miscCode misc function
// pulse; busy high outside IDLE.
module dte_diag_seq
  import dte_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = DTE_SETUP_CYC,
  parameter int unsigned STROBE_CYC = DTE_STROBE_CYC,
  parameter int unsigned HOLD_CYC   = DTE_HOLD_CYC
) (
  input  logic        clk,
  input  logic        CROBAR,
  input  logic [1:0]  reqValid,
  input  logic [1:0]  reqType0,
  input  logic [1:0]  reqType1,
  input  logic [6:0]  reqDs0,
  input  logic [6:0]  reqDs1,
  input  logic [35:0] reqData0,
  input  logic [35:0] reqData1,
  output logic [1:0]  reqAck,
  output logic [35:0] replyData,
  input  logic [35:0] ebusDataIn,
  output logic [6:0]  ds,
  output logic        diagStrobe,
  output logic        driving,
  output logic [35:0] drvData,
  output logic        miscStrobe,
  output logic [6:0]  miscCode,
  output logic        busy
);

  if (SETUP_CYC > DTE_CNT_MAX || STROBE_CYC > DTE_CNT_MAX || HOLD_CYC > DTE_CNT_MAX) begin : g_param_chk
    $error("dte_diag_seq: timing parameters must not exceed 255");
  end

  localparam logic [7:0] SETUP_N  = 8'(SETUP_CYC);
  localparam logic [7:0] STROBE_N = 8'(dte_clamp1(STROBE_CYC));
  localparam logic [7:0] HOLD_N   = 8'(HOLD_CYC);

  tDiagState   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  tFEReqType   type_q, type_d;
  logic [6:0]  ds_q, ds_d;
  logic [35:0] data_q, data_d;
  logic [35:0] reply_q, reply_d;
  logic        last_q, last_d;
  logic        sel_q, sel_d;
  logic [1:0]  grant;

  dte_rr_arb2 u_arb (
    .req_i        (reqValid),
    .en_i         (state_q == IDLE),
    .last_grant_i (last_q),
    .grant_o      (grant)
  );

  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      type_q  <= DiagFunc;
      ds_q    <= '0;
      data_q  <= '0;
      reply_q <= '0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      ds_q    <= ds_d;
      data_q  <= data_d;
      reply_q <= reply_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  // cnt_q counts cycles spent in the current phase; it restarts on every phase change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    type_d  = type_q;
    ds_d    = ds_q;
    data_d  = data_q;
    reply_d = reply_q;
    last_d  = last_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (grant != 2'b00) begin
          sel_d  = grant[1];
          last_d = grant[1];
          type_d = grant[1] ? tFEReqType'(reqType1) : tFEReqType'(reqType0);
          ds_d   = grant[1] ? reqDs1 : reqDs0;
          data_d = grant[1] ? reqData1 : reqData0;
          if (type_d == Misc) begin
            state_d = DONE;
          end else if (SETUP_N != 8'd0) begin
            state_d = SETUP;
          end else begin
            state_d = STROBE;
          end
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_N - 8'd1) begin
          state_d = STROBE;
          cnt_d   = '0;
        end
      end
      STROBE: begin
        if (cnt_q == STROBE_N - 8'd1) begin
          reply_d = (type_q == DiagWrite) ? data_q : ebusDataIn;
          state_d = (HOLD_N != 8'd0) ? HOLD : DONE;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_N - 8'd1) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    reqAck     = 2'b00;
    ds         = '0;
    diagStrobe = 1'b0;
    driving    = 1'b0;
    drvData    = '0;
    miscStrobe = 1'b0;
    miscCode   = '0;
    busy       = (state_q != IDLE);
    replyData  = reply_q;
    case (state_q)
      SETUP, STROBE, HOLD: begin
        ds         = ds_q;
        diagStrobe = (state_q == STROBE);
        driving    = (type_q == DiagWrite);
        drvData    = (type_q == DiagWrite) ? data_q : '0;
      end
      DONE: begin
        reqAck[sel_q] = 1'b1;
        if (type_q == Misc) begin
          miscStrobe = 1'b1;
          miscCode   = ds_q;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_dte_diag_seq.sv
// tb/tb_dte_diag_seq.sv - self-checking bench for dte_diag_seq
module tb_dte_diag_seq;
  import dte_pkg::*;

  localparam int S = 1;
  localparam int T = 2;
  localparam int H = 1;

  logic        clk = 1'b0;
  logic        CROBAR;
  logic [1:0]  reqValid, zValid;
  logic [1:0]  reqType0, reqType1;
  logic [6:0]  reqDs0, reqDs1;
  logic [35:0] reqData0, reqData1, ebusDataIn;
  logic [1:0]  reqAck, z_reqAck;
  logic [35:0] replyData, z_replyData, drvData, z_drvData;
  logic [6:0]  ds, z_ds, miscCode, z_miscCode;
  logic        diagStrobe, z_diagStrobe, driving, z_driving;
  logic        miscStrobe, z_miscStrobe, busy, z_busy;

  int errors = 0;
  int checks = 0;
  int n = 0;

  // Transaction-level reference: the active grant, its start cycle and latched fields.
  bit          act = 1'b0;
  bit          last = 1'b1;
  bit          gnow = 1'b0;
  int          st = 0;
  int          g = 0;
  logic [1:0]  ty = 2'd0;
  logic [6:0]  mds = 7'd0;
  logic [35:0] mdata = 36'd0;
  logic [35:0] mreply = 36'd0;

  always #5 clk = ~clk;

  dte_diag_seq u_dut (
    .clk(clk), .CROBAR(CROBAR), .reqValid(reqValid),
    .reqType0(reqType0), .reqType1(reqType1), .reqDs0(reqDs0), .reqDs1(reqDs1),
    .reqData0(reqData0), .reqData1(reqData1), .reqAck(reqAck), .replyData(replyData),
    .ebusDataIn(ebusDataIn), .ds(ds), .diagStrobe(diagStrobe), .driving(driving),
    .drvData(drvData), .miscStrobe(miscStrobe), .miscCode(miscCode), .busy(busy)
  );

  dte_diag_seq #(.SETUP_CYC(0), .STROBE_CYC(0), .HOLD_CYC(0)) u_zero (
    .clk(clk), .CROBAR(CROBAR), .reqValid(zValid),
    .reqType0(reqType0), .reqType1(reqType1), .reqDs0(reqDs0), .reqDs1(reqDs1),
    .reqData0(reqData0), .reqData1(reqData1), .reqAck(z_reqAck), .replyData(z_replyData),
    .ebusDataIn(ebusDataIn), .ds(z_ds), .diagStrobe(z_diagStrobe), .driving(z_driving),
    .drvData(z_drvData), .miscStrobe(z_miscStrobe), .miscCode(z_miscCode), .busy(z_busy)
  );

  function automatic logic [35:0] rnd36();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[35:0];
  endfunction

  // Grant-to-ack distance for a request type.
  function automatic int len_of(input logic [1:0] t);
    return (t == Misc) ? 1 : 1 + S + T + H;
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: got %0h want %0h", tag, n, obs, exp);
    end
  endtask

  task automatic check_cycle();
    int off, len;
    logic [1:0]  e_ack;
    logic [6:0]  e_ds, e_mc;
    logic [35:0] e_dd;
    logic        e_str, e_drv, e_ms, e_busy;
    e_ack = 2'b00; e_ds = 7'd0; e_mc = 7'd0; e_dd = 36'd0;
    e_str = 1'b0; e_drv = 1'b0; e_ms = 1'b0; e_busy = 1'b0;
    off = n - st;
    len = len_of(ty);
    if (act && off >= 1 && off <= len) begin
      e_busy = 1'b1;
      if (off == len) begin
        e_ack[g] = 1'b1;
        if (ty == Misc) begin
          e_ms = 1'b1;
          e_mc = mds;
        end
      end else begin
        e_ds  = mds;
        e_drv = (ty == DiagWrite);
        e_dd  = e_drv ? mdata : 36'd0;
        e_str = (off > S) && (off <= S + T);
      end
    end
    chk("ack", 36'(reqAck), 36'(e_ack));
    chk("ds", 36'(ds), 36'(e_ds));
    chk("diagStrobe", 36'(diagStrobe), 36'(e_str));
    chk("driving", 36'(driving), 36'(e_drv));
    chk("drvData", drvData, e_dd);
    chk("miscStrobe", 36'(miscStrobe), 36'(e_ms));
    chk("miscCode", 36'(miscCode), 36'(e_mc));
    chk("busy", 36'(busy), 36'(e_busy));
    if (e_ack != 2'b00 && ty != Misc) chk("replyData", replyData, mreply);
  endtask

  // Applies this cycle's inputs to the reference: reset, bus capture, new grant.
  task automatic model_update();
    int off;
    gnow = 1'b0;
    if (CROBAR) begin
      act  = 1'b0;
      last = 1'b1;
      return;
    end
    off = n - st;
    if (act && ty != Misc && off == S + T) mreply = (ty == DiagWrite) ? mdata : ebusDataIn;
    if ((!act || off > len_of(ty)) && reqValid != 2'b00) begin
      if (reqValid == 2'b11) g = last ? 0 : 1;
      else g = reqValid[1] ? 1 : 0;
      last  = (g == 1);
      ty    = (g == 1) ? reqType1 : reqType0;
      mds   = (g == 1) ? reqDs1 : reqDs0;
      mdata = (g == 1) ? reqData1 : reqData0;
      act   = 1'b1;
      st    = n;
      gnow  = 1'b1;
    end
  endtask

  task automatic cyc();
    model_update();
    @(posedge clk);
    #1;
    n++;
    check_cycle();
  endtask

  task automatic set_fields(input int r);
    if (r == 0) begin
      reqType0 = 2'($urandom_range(3, 0)); reqDs0 = 7'($urandom_range(127, 0)); reqData0 = rnd36();
    end else begin
      reqType1 = 2'($urandom_range(3, 0)); reqDs1 = 7'($urandom_range(127, 0)); reqData1 = rnd36();
    end
  endtask

  initial begin
    int          acks;
    int          ack_cyc[4];
    logic [1:0]  ack_who[4];
    bit          owed[2];
    bit          found;
    bit          acked;
    logic [35:0] zexp;

    CROBAR = 1'b1; reqValid = 2'b00; zValid = 2'b00;
    reqType0 = 2'd0; reqType1 = 2'd0; reqDs0 = 7'd0; reqDs1 = 7'd0;
    reqData0 = 36'd0; reqData1 = 36'd0; ebusDataIn = 36'd0;
    cyc();
    cyc();
    chk("rst_reply", replyData, 36'd0);
    chk("rst_busy", 36'(busy), 36'd0);
    chk("z_rst_reply", z_replyData, 36'd0);
    chk("z_rst_busy", 36'(z_busy), 36'd0);
    CROBAR = 1'b0;
    cyc();

    // Front-end DiagRead.
    reqValid = 2'b01; reqType0 = DiagRead; reqDs0 = 7'o014; ebusDataIn = 36'o123456701234;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("rd_strobe", 36'(diagStrobe), 36'(k == 2 || k == 3));
      chk("rd_ack", 36'(reqAck), (k == 5) ? 36'd1 : 36'd0);
    end
    chk("rd_reply", replyData, 36'o123456701234);
    reqValid = 2'b00;
    cyc();

    // Maintenance DiagWrite; its inputs change after the grant.
    reqValid = 2'b10; reqType1 = DiagWrite; reqDs1 = 7'o071; reqData1 = 36'o777000777000;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("wr_driving", 36'(driving), 36'(k < 5));
      chk("wr_drvdata", drvData, (k < 5) ? 36'o777000777000 : 36'd0);
      chk("wr_ds", 36'(ds), (k < 5) ? 36'o071 : 36'd0);
      if (k == 1) begin
        reqData1 = rnd36();
        reqDs1   = 7'h55;
      end
    end
    reqValid = 2'b00;
    cyc();

    // Both requesters continuously valid.
    reqValid = 2'b11; reqType0 = DiagFunc; reqType1 = DiagFunc;
    reqData0 = rnd36(); reqData1 = rnd36();
    acks = 0;
    for (int k = 0; k < 40 && acks < 4; k++) begin
      cyc();
      if (reqAck != 2'b00) begin
        ack_cyc[acks] = n;
        ack_who[acks] = reqAck;
        acks++;
      end
    end
    reqValid = 2'b00;
    cyc();
    chk("rr_acks", 36'(acks), 36'd4);
    for (int i = 0; i < acks; i++) begin
      chk("rr_who", 36'(ack_who[i]), (i % 2 == 0) ? 36'd1 : 36'd2);
      if (i > 0) chk("rr_gap", 36'(ack_cyc[i] - ack_cyc[i-1]), 36'd6);
    end

    // Misc clrCROBAR from the front-end.
    reqValid = 2'b01; reqType0 = Misc; reqDs0 = clrCROBAR;
    cyc();
    chk("misc_strobe", 36'(miscStrobe), 36'd1);
    chk("misc_code", 36'(miscCode), 36'd0);
    chk("misc_ack", 36'(reqAck), 36'd1);
    chk("misc_diag", 36'(diagStrobe), 36'd0);
    reqValid = 2'b00;
    cyc();
    chk("misc_after", 36'(miscStrobe), 36'd0);

    // Reset during STROBE with both requesters pending.
    reqValid = 2'b10; reqType1 = DiagWrite; reqDs1 = 7'o033; reqData1 = rnd36();
    cyc();
    reqValid = 2'b11; reqType0 = DiagRead; reqDs0 = 7'o002;
    cyc();
    chk("pre_rst_strobe", 36'(diagStrobe), 36'd1);
    CROBAR = 1'b1;
    cyc();
    chk("rst_strobe", 36'(diagStrobe), 36'd0);
    chk("rst_driving", 36'(driving), 36'd0);
    chk("rst_ack", 36'(reqAck), 36'd0);
    CROBAR = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cyc();
      if (reqAck != 2'b00) begin
        found = 1'b1;
        chk("regrant_first", 36'(reqAck), 36'd1);
        reqValid[0] = 1'b0;
      end
    end
    chk("regrant_found", 36'(found), 36'd1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cyc();
      if (reqAck != 2'b00) begin
        found = 1'b1;
        chk("regrant_second", 36'(reqAck), 36'd2);
        reqValid[1] = 1'b0;
      end
    end
    chk("regrant2_found", 36'(found), 36'd1);
    cyc();

    // Zero-length phases on the second instance.
    zValid = 2'b01; reqType0 = DiagRead; reqDs0 = 7'o014; ebusDataIn = rnd36();
    cyc();
    chk("z_strobe1", 36'(z_diagStrobe), 36'd1);
    chk("z_ds1", 36'(z_ds), 36'o014);
    chk("z_ack1", 36'(z_reqAck), 36'd0);
    chk("z_driving1", 36'(z_driving), 36'd0);
    chk("z_drvdata1", z_drvData, 36'd0);
    zexp = rnd36();
    ebusDataIn = zexp;
    cyc();
    chk("z_ack2", 36'(z_reqAck), 36'd1);
    chk("z_reply2", z_replyData, zexp);
    chk("z_strobe2", 36'(z_diagStrobe), 36'd0);
    chk("z_misc2", 36'(z_miscStrobe), 36'd0);
    chk("z_code2", 36'(z_miscCode), 36'd0);
    zValid = 2'b00;
    cyc();
    chk("z_idle", 36'(z_busy), 36'd0);

    // Randomized traffic against the reference.
    owed[0] = 1'b0;
    owed[1] = 1'b0;
    for (int c = 0; c < 800; c++) begin
      for (int r = 0; r < 2; r++) begin
        acked = act && (n - st == len_of(ty)) && (g == r);
        if (owed[r]) begin
          if (acked) begin
            owed[r] = 1'b0;
            reqValid[r] = 1'b0;
            if ($urandom_range(2, 0) == 0) begin
              set_fields(r);
              reqValid[r] = 1'b1;
            end
          end else begin
            if ($urandom_range(7, 0) == 0) reqValid[r] = 1'b0;
            if ($urandom_range(1, 0) == 0) set_fields(r);
          end
        end else if (!reqValid[r] && $urandom_range(2, 0) == 0) begin
          set_fields(r);
          reqValid[r] = 1'b1;
        end
      end
      ebusDataIn = rnd36();
      CROBAR = ($urandom_range(99, 0) == 0);
      if (CROBAR) begin
        owed[0] = 1'b0;
        owed[1] = 1'b0;
      end
      cyc();
      if (gnow) owed[g] = 1'b1;
    end
    CROBAR = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
